// File: rtl/led_pwm_fader.sv
// Two-channel LED fader: ramps each channel's PWM brightness toward its on/off request.
// Latency: REQ registered 1 cycle, level moves one STEP per tick, LED/BUSY registered 1 cycle after level.
// Backpressure: none; REQ is sampled every cycle and there is no handshake.
//
// Ports:
//   CLK        system clock
//   nRST       synchronous reset, active-low
//   REQ[1:0]   per-channel on request, active-high (1 = ramp to full, 0 = ramp to dark)
//   LED[1:0]   LED pins, active-low (0 = lit)
//   BUSY[1:0]  per-channel ramp in progress
module led_pwm_fader #(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 46875,
   parameter int STEP     = 1
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [1:0] REQ,
   output logic [1:0] LED,
   output logic [1:0] BUSY
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PWM_BITS-1:0] MAX    = '1;
   localparam logic [PWM_BITS:0]   MAX_X  = {1'b0, MAX};
   localparam logic [PWM_BITS:0]   STEP_X = (PWM_BITS+1)'(STEP);
   localparam logic [PWM_BITS-1:0] STEP_L = PWM_BITS'(STEP);
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_RISE = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_FALL = 2'd3;

   logic [1:0]          req_q;
   logic [DIV_W-1:0]    div_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] level [2];
   logic [1:0]          state [2];

   logic                tick;
   logic [PWM_BITS:0]   up    [2];
   logic [PWM_BITS-1:0] lvl_n [2];
   logic [1:0]          st_n  [2];
   logic [1:0]          lit;
   logic [1:0]          busy_c;

   // With STEP_DIV=1 the counter never leaves 0, so tick is permanently high.
   assign tick = (div_cnt == DIV_LAST);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // One extra bit so level+STEP can be seen exceeding MAX before clamping.
         up[i]     = {1'b0, level[i]} + STEP_X;
         lvl_n[i]  = level[i];
         st_n[i]   = state[i];
         lit[i]    = (level[i] == MAX) | (pwm_cnt < level[i]);
         busy_c[i] = (state[i] == S_RISE) | (state[i] == S_FALL);
         if (tick) begin
            // Both directions start from the current level, so a reversal
            // mid-ramp never jumps to an end point.
            if (req_q[i]) begin
               lvl_n[i] = (up[i] > MAX_X) ? MAX : up[i][PWM_BITS-1:0];
               st_n[i]  = (lvl_n[i] == MAX) ? S_ON : S_RISE;
            end else begin
               lvl_n[i] = ({1'b0, level[i]} < STEP_X) ? '0 : level[i] - STEP_L;
               st_n[i]  = (lvl_n[i] == '0) ? S_OFF : S_FALL;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         req_q   <= 2'b00;
         div_cnt <= '0;
         pwm_cnt <= '0;
         LED     <= 2'b11;
         BUSY    <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            level[i] <= '0;
            state[i] <= S_OFF;
         end
      end else begin
         req_q   <= REQ;
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         LED     <= ~lit;
         BUSY    <= busy_c;
         for (int i = 0; i < 2; i++) begin
            level[i] <= lvl_n[i];
            state[i] <= st_n[i];
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: three instances (different STEP_DIV/STEP) driven
// by a directed sequence, with a per-cycle reference model feeding a queue of
// expected LED/BUSY values that are popped and compared after each edge.
module tb_led_pwm_fader;

   localparam int MAXV = 15;
   localparam int DIVP [3] = '{2, 16, 2};
   localparam int STPP [3] = '{1, 4, 4};

   logic       CLK = 1'b0;
   logic       nRST;
   logic [1:0] req  [3];
   logic [1:0] led  [3];
   logic [1:0] busy [3];

   always #5 CLK = ~CLK;

   led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(2),  .STEP(1)) u_a (
      .CLK(CLK), .nRST(nRST), .REQ(req[0]), .LED(led[0]), .BUSY(busy[0]));
   led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(16), .STEP(4)) u_b (
      .CLK(CLK), .nRST(nRST), .REQ(req[1]), .LED(led[1]), .BUSY(busy[1]));
   led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(2),  .STEP(4)) u_c (
      .CLK(CLK), .nRST(nRST), .REQ(req[2]), .LED(led[2]), .BUSY(busy[2]));

   // Reference model: plain integer brightness; a channel is ramping exactly
   // when its level is strictly between 0 and MAXV.
   int         m_div [3];
   int         m_pwm [3];
   int         m_lvl [3][2];
   logic [1:0] m_reqq [3];
   logic [1:0] m_led  [3];
   logic [1:0] m_busy [3];

   logic [11:0] exp_q [$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      n_total++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_step();
      logic [11:0] e;
      e = '0;
      for (int d = 0; d < 3; d++) begin
         if (!nRST) begin
            m_div[d]  = 0;
            m_pwm[d]  = 0;
            m_reqq[d] = 2'b00;
            m_led[d]  = 2'b11;
            m_busy[d] = 2'b00;
            for (int i = 0; i < 2; i++) m_lvl[d][i] = 0;
         end else begin
            bit t;
            t = (m_div[d] == DIVP[d] - 1);
            for (int i = 0; i < 2; i++) begin
               int lv;
               lv = m_lvl[d][i];
               m_led[d][i]  = !((lv == MAXV) || (m_pwm[d] < lv));
               m_busy[d][i] = (lv != 0) && (lv != MAXV);
               if (t) begin
                  if (m_reqq[d][i]) lv = (lv + STPP[d] > MAXV) ? MAXV : lv + STPP[d];
                  else              lv = (lv < STPP[d]) ? 0 : lv - STPP[d];
               end
               m_lvl[d][i] = lv;
            end
            m_div[d]  = t ? 0 : m_div[d] + 1;
            m_pwm[d]  = (m_pwm[d] + 1) % (MAXV + 1);
            m_reqq[d] = req[d];
         end
         e[d*4 +: 2]   = m_led[d];
         e[d*4+2 +: 2] = m_busy[d];
      end
      exp_q.push_back(e);
   endtask

   // Inputs are already set; predict this edge, clock it, compare 1 time unit later.
   task automatic cycle();
      logic [11:0] e;
      model_step();
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("led[%0d]", d),  int'(led[d]),  int'(e[d*4 +: 2]));
         chk($sformatf("busy[%0d]", d), int'(busy[d]), int'(e[d*4+2 +: 2]));
      end
   endtask

   initial begin
      int low_b;
      int low_a;

      for (int d = 0; d < 3; d++) begin
         m_div[d] = 0; m_pwm[d] = 0; m_reqq[d] = 2'b00;
         m_led[d] = 2'b11; m_busy[d] = 2'b00;
         m_lvl[d][0] = 0; m_lvl[d][1] = 0;
      end

      // Reset hold with requests asserted.
      nRST = 1'b0;
      for (int d = 0; d < 3; d++) req[d] = 2'b11;
      repeat (10) cycle();
      chk("rst_led", int'(led[0]), 3);
      chk("rst_busy", int'(busy[0]), 0);

      // Release: u_a full rise on ch0, u_b duty check on ch1, u_c saturating rise on ch0.
      nRST   = 1'b1;
      req[0] = 2'b01;
      req[1] = 2'b10;
      req[2] = 2'b01;
      low_b  = 0;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         // Outputs after edges 17..32 reflect u_b ch1 at level 4.
         if (k >= 17 && k <= 32 && led[1][1] == 1'b0) low_b++;
      end
      chk("duty_b_lvl4", low_b, 4);
      chk("rise_a_led", int'(led[0]), 2);
      chk("rise_a_busy", int'(busy[0]), 0);
      chk("sat_c_led", int'(led[2]), 2);
      chk("sat_c_busy", int'(busy[2]), 0);

      low_a = 0;
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (led[0][0] == 1'b0) low_a++;
      end
      chk("full_a_low", low_a, 16);

      // Fall from full on u_a and u_c (u_c clamps 15,11,7,3,0).
      req[0] = 2'b00;
      req[2] = 2'b00;
      repeat (36) cycle();
      chk("fall_a_led", int'(led[0]), 3);
      chk("fall_a_busy", int'(busy[0]), 0);
      chk("fall_c_led", int'(led[2]), 3);

      // Reversal mid-ramp on u_a.
      req[0] = 2'b01;
      repeat (14) cycle();
      chk("rev_a_busy_up", int'(busy[0]), 1);
      req[0] = 2'b00;
      repeat (20) cycle();
      chk("rev_a_led", int'(led[0]), 3);
      chk("rev_a_busy", int'(busy[0]), 0);

      // Reset pulse mid-ramp, request held.
      req[0] = 2'b01;
      repeat (19) cycle();
      chk("mid_a_busy", int'(busy[0]), 1);
      nRST = 1'b0;
      cycle();
      chk("midrst_led", int'(led[0]), 3);
      chk("midrst_busy", int'(busy[0]), 0);
      nRST = 1'b1;
      repeat (10) cycle();
      chk("restart_busy", int'(busy[0]), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
